// File: rtl/dense_mac_pkg.sv
// Shared types and helpers for the dense-stage MAC array.
// Optional build macro: DENSE_MAC_SAT_EN (saturating accumulate in dense_mac_lane).
package dense_mac_pkg;

   typedef enum logic {StIdle, StRun} state_e;

   // Accumulator width: full signed product plus guard bits.
   function automatic int unsigned acc_width(int unsigned data_w, int unsigned guard);
      return 2 * data_w + guard;
   endfunction

   // LSB position of a lane inside a packed lane vector.
   function automatic int unsigned lane_lsb(int unsigned lane, int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One MAC lane: MULT_LAT-deep signed multiplier with clock enable, followed by a
// load/add accumulator that doubles as the lane's output register.
// Optional build macro: DENSE_MAC_SAT_EN (saturate each step instead of wrapping).
module dense_mac_lane #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MULT_LAT = 3,
   parameter int unsigned ACC_W    = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic              clear_i,
   input  logic              acc_en_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] fea_i,
   input  logic [DATA_W-1:0] wgt_i,
   output logic [ACC_W-1:0]  acc_o
);

   logic signed [2*DATA_W-1:0] prod_q [MULT_LAT];
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    base;
   logic signed [ACC_W-1:0]    sum;
   logic signed [ACC_W-1:0]    acc_d;
   logic signed [ACC_W-1:0]    acc_q;

   // Multiplier pipeline; frozen as a whole while ce_i is low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned k = 0; k < MULT_LAT; k++) prod_q[k] <= '0;
      end else if (ce_i) begin
         prod_q[0] <= $signed(fea_i) * $signed(wgt_i);
         for (int unsigned k = 1; k < MULT_LAT; k++) prod_q[k] <= prod_q[k-1];
      end
   end

   // Load starts a group from zero; otherwise add onto the running sum.
   always_comb begin
      prod_ext = ACC_W'(prod_q[MULT_LAT-1]);
      base     = load_i ? '0 : acc_q;
      sum      = base + prod_ext;
`ifdef DENSE_MAC_SAT_EN
      // Same-sign operands giving a different-sign sum means overflow.
      if ((base[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1])) begin
         acc_d = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         acc_d = sum;
      end
`else
      acc_d = sum;
`endif
   end

   // Accumulator / output register.
   always_ff @(posedge clk) begin
      if (!rst || clear_i) begin
         acc_q <= '0;
      end else if (acc_en_i) begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/dense_mac_array.sv
// NUM_LANES-wide signed MAC array with valid/ready on both sides and a run-time
// accumulation group length (0 or 1 = pass-through).
// Optional build macro: DENSE_MAC_SAT_EN (saturating accumulate, see dense_mac_lane).
module dense_mac_array
   import dense_mac_pkg::*;
#(
   parameter int unsigned NUM_LANES = 25,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MULT_LAT  = 3,
   parameter int unsigned ACC_GUARD = 8,
   localparam int unsigned ACC_W    = acc_width(DATA_W, ACC_GUARD)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_i,
   input  logic [7:0]                  cfg_acc_len_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [NUM_LANES*DATA_W-1:0] in_fea_i,
   input  logic [NUM_LANES*DATA_W-1:0] in_wgt_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [NUM_LANES*ACC_W-1:0]  out_data_o,
   output logic                        out_last_o,
   output logic                        busy_o
);

   state_e              state_q;
   logic [7:0]          acc_len_q;
   logic [7:0]          cnt_q;
   logic [MULT_LAT-1:0] vld_q;
   logic [MULT_LAT-1:0] last_q;
   logic [MULT_LAT-1:0] load_q;
   logic                out_valid_q;
   logic                out_last_q;

   logic stall;
   logic accept;
   logic pass;
   logic beat_first;
   logic beat_last;
   logic acc_en;

   // Handshake, stall and beat position within the current group.
   always_comb begin
      stall      = out_valid_q && !out_ready_i;
      in_ready_o = (state_q == StRun) && !stall && !start_i;
      accept     = in_valid_i && in_ready_o;
      pass       = (acc_len_q <= 8'd1);
      beat_first = (cnt_q == 8'd0);
      beat_last  = pass || (cnt_q == acc_len_q - 8'd1);
      acc_en     = vld_q[MULT_LAT-1] && !stall;
   end

   // Control FSM: leaves IDLE on start and stays in RUN until reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         acc_len_q <= '0;
      end else if (start_i) begin
         state_q   <= StRun;
         acc_len_q <= cfg_acc_len_i;
      end
   end

   // Valid/last/load shift register alongside the multipliers, plus beat counter.
   always_ff @(posedge clk) begin
      if (!rst || start_i) begin
         vld_q       <= '0;
         last_q      <= '0;
         load_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (!stall) begin
         vld_q[0]  <= accept;
         last_q[0] <= beat_last;
         load_q[0] <= beat_first;
         for (int unsigned k = 1; k < MULT_LAT; k++) begin
            vld_q[k]  <= vld_q[k-1];
            last_q[k] <= last_q[k-1];
            load_q[k] <= load_q[k-1];
         end
         out_valid_q <= vld_q[MULT_LAT-1] && last_q[MULT_LAT-1];
         out_last_q  <= vld_q[MULT_LAT-1] && last_q[MULT_LAT-1];
         if (accept) cnt_q <= beat_last ? 8'd0 : cnt_q + 8'd1;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      dense_mac_lane #(
         .DATA_W   (DATA_W),
         .MULT_LAT (MULT_LAT),
         .ACC_W    (ACC_W)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .ce_i     (!stall),
         .clear_i  (start_i),
         .acc_en_i (acc_en),
         .load_i   (load_q[MULT_LAT-1]),
         .fea_i    (in_fea_i[lane_lsb(i, DATA_W) +: DATA_W]),
         .wgt_i    (in_wgt_i[lane_lsb(i, DATA_W) +: DATA_W]),
         .acc_o    (out_data_o[lane_lsb(i, ACC_W) +: ACC_W])
      );
   end

   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign busy_o      = (|vld_q) || (cnt_q != 8'd0);

endmodule

// File: tb/tb_dense_mac_array.sv
// Scoreboard bench for dense_mac_array (4 lanes, 16-bit data, no guard bits so
// 32-bit accumulators can overflow). Follows DENSE_MAC_SAT_EN for the model.
module tb_dense_mac_array;

   localparam int NL = 4;
   localparam int DW = 16;
   localparam int ML = 3;
   localparam int AG = 0;
   localparam int AW = 32;
   localparam longint AccMax = (64'sd1 <<< 31) - 64'sd1;
   localparam longint AccMin = -(64'sd1 <<< 31);

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        cfg = 8'd0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [NL*DW-1:0]  fea = '0;
   logic [NL*DW-1:0]  wgt = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [NL*AW-1:0]  out_data;
   logic              out_last;
   logic              busy;

   dense_mac_array #(
      .NUM_LANES (NL),
      .DATA_W    (DW),
      .MULT_LAT  (ML),
      .ACC_GUARD (AG)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .cfg_acc_len_i (cfg),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_fea_i      (fea),
      .in_wgt_i      (wgt),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_data_o    (out_data),
      .out_last_o    (out_last),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out, got no event expected one", nm);
   endtask

   // Reference model: per-lane running sums with group length and beat position.
   logic [NL*AW-1:0] exp_q [$];
   int               m_len = 0;
   int               m_cnt = 0;
   longint           m_acc [NL];

   function automatic longint step(input longint a, input longint p);
      longint s;
      s = a + p;
`ifdef DENSE_MAC_SAT_EN
      if (s > AccMax) s = AccMax;
      else if (s < AccMin) s = AccMin;
`else
      s = longint'(int'(s));
`endif
      return s;
   endfunction

   task automatic model_beat(input logic [NL*DW-1:0] f, input logic [NL*DW-1:0] w);
      logic [NL*AW-1:0] d;
      longint           p;
      bit               pass;
      pass = (m_len <= 1);
      d    = '0;
      for (int l = 0; l < NL; l++) begin
         p = longint'($signed(f[l*DW +: DW])) * longint'($signed(w[l*DW +: DW]));
         m_acc[l] = (m_cnt == 0 || pass) ? step(0, p) : step(m_acc[l], p);
      end
      m_cnt++;
      if (pass || m_cnt == m_len) begin
         for (int l = 0; l < NL; l++) d[l*AW +: AW] = m_acc[l][AW-1:0];
         exp_q.push_back(d);
         m_cnt = 0;
      end
   endtask

   // Downstream ready: forced low, random, or always high.
   bit force_low = 1'b0;
   bit rdy_rand  = 1'b0;
   always @(posedge clk) begin
      #1;
      out_ready = force_low ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
   end

   // Monitor: pops on every handshake and checks hold-stability while stalled.
   logic [NL*AW-1:0] prev_data = '0;
   logic             prev_last = 1'b0;
   logic             prev_stall = 1'b0;
   logic [NL*AW-1:0] e;
   always @(negedge clk) begin
      if (prev_stall) begin
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_data", out_data, prev_data);
         chk("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected no output", out_data);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e);
            chk("out_last", out_last, 1'b1);
         end
      end
      prev_stall <= rst && out_valid && !out_ready;
      prev_data  <= out_data;
      prev_last  <= out_last;
   end

   task automatic do_start(input int len);
      start = 1'b1;
      cfg   = 8'(len);
      @(posedge clk);
      #1;
      start = 1'b0;
      m_len = len;
      m_cnt = 0;
   endtask

   task automatic send_beat(input logic [NL*DW-1:0] f, input logic [NL*DW-1:0] w);
      bit ok;
      ok       = 1'b0;
      fea      = f;
      wgt      = w;
      in_valid = 1'b1;
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) timeout("beat_accept");
      else model_beat(f, w);
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 1000 && !done; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && !out_valid) done = 1'b1;
      end
      if (!done) timeout("drain");
      @(posedge clk);
      #1;
   endtask

   logic [NL*DW-1:0] f, w;
   int               len, n;
   bit               seen;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_in_ready", in_ready, 1'b0);

      // Pass-through with latency: lane0 3 * -2
      do_start(1);
      f = '0; w = '0;
      f[15:0] = 16'd3;
      w[15:0] = 16'hFFFE;
      send_beat(f, w);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk((i < 4) ? "latency_early" : "latency_hit", out_valid, (i == 4));
      end
      wait_drain();

      // Accumulate four beats of 100*100
      do_start(4);
      for (int i = 0; i < 4; i++) send_beat({NL{16'd100}}, {NL{16'd100}});
      wait_drain();

      // Overflow: two beats of (-32768)^2 into a 32-bit accumulator
      do_start(2);
      f = '0;
      f[15:0] = 16'h8000;
      send_beat(f, f);
      send_beat(f, f);
      wait_drain();

      // Backpressure: 8 pass-through results held behind a stalled first one
      do_start(1);
      force_low = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      fork
         begin
            for (int k = 1; k <= 8; k++) begin
               f = '0; w = '0;
               f[15:0] = 16'(k);
               w[15:0] = 16'd1;
               send_beat(f, w);
            end
         end
         begin
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
               @(negedge clk);
               if (out_valid) seen = 1'b1;
            end
            if (!seen) timeout("bp_first_result");
            for (int c = 0; c < 5; c++) begin
               if (c > 0) @(negedge clk);
               chk("bp_in_ready", in_ready, 1'b0);
               chk("bp_lane0", out_data[31:0], 32'd1);
            end
            force_low = 1'b0;
         end
      join
      wait_drain();

      // Abort a partial group, then a pass-through beat must yield 25 alone
      do_start(4);
      send_beat({NL{16'd2}}, {NL{16'd2}});
      send_beat({NL{16'd2}}, {NL{16'd2}});
      do_start(1);
      send_beat({NL{16'd5}}, {NL{16'd5}});
      wait_drain();

      // Randomised groups with random gaps and random downstream ready
      rdy_rand = 1'b1;
      for (int g = 0; g < 8; g++) begin
         case ($urandom_range(0, 5))
            0: len = 0;
            1: len = 1;
            2: len = 2;
            3: len = 3;
            4: len = 5;
            default: len = 7;
         endcase
         do_start(len);
         n = ((len <= 1) ? 1 : len) * int'($urandom_range(1, 4));
         for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            for (int l = 0; l < NL; l++) begin
               f[l*DW +: DW] = 16'($urandom);
               w[l*DW +: DW] = 16'($urandom);
            end
            send_beat(f, w);
         end
         wait_drain();
      end
      rdy_rand = 1'b0;

      // Reset while a result is held and beats are still in flight
      force_low = 1'b1;
      do_start(1);
      for (int k = 1; k <= 3; k++) send_beat({NL{16'(k)}}, {NL{16'd3}});
      seen = 1'b0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      if (!seen) timeout("rst_wait_valid");
      chk("pre_rst_busy", busy, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_in_ready", in_ready, 1'b0);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_out_last", out_last, 1'b0);
      chk("mid_rst_out_data", out_data, '0);
      chk("mid_rst_busy", busy, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      force_low = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_in_ready", in_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      do_start(1);
      send_beat({NL{16'd7}}, {NL{16'hFFF9}});
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dense_mac_array.md
# dense_mac_array

Parametrised signed multiply-accumulate array for the conv dense stage. It multiplies a feature vector by a weight vector lane by lane across NUM_LANES DSP lanes. Each lane either emits the raw product every beat or sums products over a run-time group of beats. Upstream and downstream use valid/ready handshakes with full backpressure, so the block can sit between the feature/weight buffers and the output write-back stage.

## Interface
- NUM_LANES, 25, number of parallel multiplier lanes.
- DATA_W, 16, signed operand width per lane.
- MULT_LAT, 3, multiplier pipeline depth in cycles (≥1).
- ACC_GUARD, 8, accumulator guard bits; ACC_W = 2*DATA_W + ACC_GUARD.

- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse. Aborts any work in flight, latches cfg_acc_len, enters RUN.
- cfg_acc_len  in  8  beats per accumulation group. 0 or 1 means pass-through (one output per beat).
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_fea  in  NUM_LANES*DATA_W  lane i occupies [i*DATA_W +: DATA_W], signed.
- in_wgt  in  NUM_LANES*DATA_W  same packing as in_fea, signed.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  NUM_LANES*ACC_W  lane i occupies [i*ACC_W +: ACC_W], signed.
- out_last  out  1  high with the final result of a group; always high in pass-through mode.
- busy  out  1  high while any beat is in the pipeline or any group is partially accumulated.

## Operation
- State machine:
  - IDLE: entered on reset. in_ready=0.
  - start → RUN.
  - RUN: in_ready = !stall. The block stays in RUN indefinitely; there is no return to IDLE except by reset.
- A beat is accepted when in_valid && in_ready.
- Each lane's product is the full 2*DATA_W-bit signed product, sign-extended to ACC_W.
- Beat counter:
  - Counts accepted beats, 0 .. cfg_acc_len-1, and wraps to 0.
  - The beat at count 0 loads the accumulator with its product. Later beats add their product.
  - The result is emitted after the beat at count cfg_acc_len-1 is accumulated.
- Pass-through (cfg_acc_len ≤ 1): every beat loads the accumulator and emits.
- Arithmetic wraps modulo 2^ACC_W unless DENSE_MAC_SAT_EN is defined.
- Stall: stall = out_valid && !out_ready. Stall freezes the multiplier pipeline (DSP ce), the valid/last shift register, the accumulator and the beat counter.
- start during RUN:
  - Clears the pipeline valid bits, accumulators, beat counter and out_valid in the same edge.
  - A result on out_valid in that cycle is dropped.
  - The new cfg_acc_len takes effect from the next beat.
- start together with in_valid: the beat is not accepted that cycle (in_ready is 0 in the start cycle).
- Reset mid-operation clears all state in one edge, with no partial output.

## Timing
- Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, state=IDLE, counter=0, accumulators=0.
- Latency with no stall: a result appears on out_valid exactly MULT_LAT+1 cycles after the beat that closes its group was accepted. MULT_LAT cycles are the multiply; 1 cycle is the accumulate and output register.
- Throughput: one beat per cycle in both modes.
- out_data and out_last are held stable while out_valid && !out_ready.
- out_valid drops the cycle after the handshake unless a new result arrives on that edge.
- In accumulate mode, intermediate beats do not assert out_valid.
- busy falls on the cycle after the last pipeline valid bit retires and the beat counter is 0.

## Configuration
- DENSE_MAC_SAT_EN defined:
  - Each accumulate/load step saturates to the ACC_W signed range, [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Overflow is detected from the sign bits of the two operands and the sum.
- Not defined: two's-complement wrap, with no extra logic.

## Structure
- Package dense_mac_pkg holds:
  - the ACC_W derivation function;
  - the state enum (IDLE, RUN);
  - a lane slice helper for the packed vectors.
- Sub-module dense_mac_lane is instantiated NUM_LANES times. Each instance contains:
  - the MULT_LAT-deep signed multiplier with a ce input;
  - the accumulator with load/add;
  - the optional saturation logic.
- The top level holds:
  - the FSM;
  - the beat counter;
  - the valid/last shift register;
  - the stall and handshake logic.

## Test plan
- Pass-through: start with cfg_acc_len=1; beat lane0 fea=3, wgt=-2, all other lanes 0; out_ready=1 → out_valid exactly 4 cycles later with lane0=-6, other lanes 0, out_last=1.
- Accumulate: cfg_acc_len=4; four back-to-back beats with every lane 100×100 → a single out_valid with all lanes =40000, out_last=1; no out_valid on the three earlier beats.
- Backpressure:
  - Setup: cfg_acc_len=1; stream 8 beats with lane0 products 1..8; hold out_ready=0 for 5 cycles after the first result.
  - Required: in_ready=0 while stalled; out_data frozen at 1; all 8 results delivered in order with none lost or duplicated.
- Overflow, with ACC_GUARD=0 and cfg_acc_len=2; two beats of (-32768)×(-32768):
  - DENSE_MAC_SAT_EN defined → lane=0x7FFFFFFF;
  - not defined → lane=0x80000000.
- Abort: cfg_acc_len=4; after 2 beats (2×2 each), pulse start with cfg_acc_len=1, then one beat 5×5 → the next out_valid is 25, never 8 or 33.
- Reset: assert rst=0 while out_valid=1 and busy=1 → next cycle all outputs are 0; after release, in_ready stays 0 until start.
